// File: rtl/boot_pkg.sv
// Shared types and constants for the byte-stream boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK_WAIT,
    CHECK,
    DONE,
    ERROR
  } boot_state_t;

  // Frame start marker.
  localparam logic [7:0] BOOT_HDR = 8'hA5;

endpackage

// File: rtl/boot_loader.sv
// Boot loader: receives a framed program image over a valid/ready byte
// stream, writes little-endian 32-bit words into instruction memory from
// word address 0, and releases the CPU from reset once the frame checksum
// has been verified.
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_error,
  output logic              busy
);

  // Largest accepted word count; one bit wider than the address so that a
  // full-memory image is representable.
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  boot_state_t       state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       shift_q;
  logic [7:0]        xor_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              cpu_rst_q;
  logic              load_done_q;
  logic              load_error_q;

  logic        accept;
  logic        is_hdr;
  logic [15:0] n_full;
  logic        oversize;
  logic        last_word;

  assign accept    = rx_valid && rx_ready;
  assign is_hdr    = (rx_data == BOOT_HDR);
  assign n_full    = {rx_data, len_lo_q};
  assign oversize  = ({1'b0, n_full} > CAP);
  assign last_word = ((32'(word_cnt_q) + 32'd1) == 32'(len_q));

  // State register (synchronous active-low reset).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a stalled stream (no accept) holds the state.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_d unassigned, which would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (accept && is_hdr) state_d = LEN_LO;
      LEN_LO:            if (accept) state_d = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (oversize)              state_d = ERROR;
          else if (n_full == 16'd0)  state_d = CHK_WAIT;
          else                       state_d = DATA;
        end
      end
      DATA:     if (accept && byte_cnt_q == 2'd3 && last_word) state_d = CHK_WAIT;
      CHK_WAIT: if (accept) state_d = CHECK;
      // CHK has been folded into the running XOR, so a match leaves zero.
      CHECK:    state_d = (xor_q == 8'd0) ? DONE : ERROR;
      default:  state_d = IDLE;
    endcase
  end

  // Combinational outputs decoded from state and reset.
  always_comb begin
    rx_ready = rst && (state_q != CHECK);
    busy     = state_q inside {LEN_LO, LEN_HI, DATA, CHK_WAIT, CHECK};
  end

  // Datapath: length capture, word assembly, checksum, registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_lo_q     <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      xor_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          IDLE, DONE, ERROR: begin
            if (is_hdr) begin
              cpu_rst_q    <= 1'b1;
              load_done_q  <= 1'b0;
              load_error_q <= 1'b0;
              xor_q        <= '0;
              byte_cnt_q   <= '0;
              word_cnt_q   <= '0;
            end
          end
          LEN_LO: begin
            len_lo_q <= rx_data;
            xor_q    <= xor_q ^ rx_data;
          end
          LEN_HI: begin
            len_q <= n_full;
            xor_q <= xor_q ^ rx_data;
            if (oversize) load_error_q <= 1'b1;
          end
          DATA: begin
            xor_q      <= xor_q ^ rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              // Earlier bytes sit in the low lanes, newest byte on top.
              imem_we_q    <= 1'b1;
              imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
              imem_wdata_q <= {rx_data, shift_q};
              word_cnt_q   <= word_cnt_q + 1'b1;
            end else begin
              shift_q <= {rx_data, shift_q[23:8]};
            end
          end
          CHK_WAIT: xor_q <= xor_q ^ rx_data;
          default: ;
        endcase
      end
      if (state_q == CHECK) begin
        if (xor_q == 8'd0) begin
          load_done_q <= 1'b1;
          cpu_rst_q   <= 1'b0;
        end else begin
          load_error_q <= 1'b1;
        end
      end
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed frames plus random
// programs, with expectations computed from the frame rules.
module tb_boot_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_error;
  logic              busy;

  boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_error (load_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  // Pending write expectation, checked on the negedge after the 4th byte.
  bit          pend = 1'b0;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;

  logic [31:0] wq[$];

  // Counts every cycle the write strobe is high.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and resolve any pending write check.
  task automatic neg();
    @(negedge clk);
    if (pend) begin
      pend = 1'b0;
      check("wr_we",   {31'd0, imem_we}, 32'd1);
      check("wr_addr", {{(32-ADDR_W){1'b0}}, imem_addr}, exp_addr);
      check("wr_data", imem_wdata, exp_data);
    end
  endtask

  // Send one byte; stall: 0 none, 1 one idle cycle first, 2 random.
  task automatic put(input logic [7:0] b, input int stall);
    int guard;
    bit gap;
    gap = (stall == 1) || (stall == 2 && $urandom_range(0, 1) == 1);
    if (gap) begin
      neg();
      rx_valid = 1'b0;
    end
    neg();
    rx_valid = 1'b1;
    rx_data  = b;
    guard = 0;
    while (rx_ready !== 1'b1 && guard < 20) begin
      neg();
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  // Send a full frame of n words taken from wq and check the outcome.
  task automatic run_frame(input int n, input bit bad_chk, input int stall);
    logic [7:0]  chk;
    logic [15:0] len;
    logic [31:0] w;
    int          base;
    base = wr_cnt;
    len  = 16'(n);
    put(8'hA5, stall);
    put(len[7:0], stall);
    put(len[15:8], stall);
    chk = len[7:0] ^ len[15:8];
    for (int k = 0; k < n; k++) begin
      w = wq[k];
      for (int b = 0; b < 4; b++) begin
        chk ^= w[8*b +: 8];
        put(w[8*b +: 8], stall);
      end
      pend     = 1'b1;
      exp_addr = 32'(k);
      exp_data = w;
    end
    if (bad_chk) chk ^= 8'h01;
    put(chk, stall);
    neg();
    rx_valid = 1'b0;
    check("check_busy",  {31'd0, busy}, 32'd1);
    check("check_ready", {31'd0, rx_ready}, 32'd0);
    neg();
    check("fin_done",  {31'd0, load_done},  {31'd0, !bad_chk});
    check("fin_error", {31'd0, load_error}, {31'd0, bad_chk});
    check("fin_cpurst", {31'd0, cpu_rst},   {31'd0, bad_chk});
    check("fin_busy",  {31'd0, busy}, 32'd0);
    check("fin_ready", {31'd0, rx_ready}, 32'd1);
    check("fin_writes", 32'(wr_cnt - base), 32'(n));
  endtask

  task automatic load_prog1();
    wq.delete();
    wq.push_back(32'h00003083);
    wq.push_back(32'h00803103);
    wq.push_back(32'h002081B3);
    wq.push_back(32'h00300F93);
  endtask

  initial begin
    int          base;
    logic [31:0] w;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_cpurst", {31'd0, cpu_rst}, 32'd1);
    check("rst_we",     {31'd0, imem_we}, 32'd0);
    check("rst_addr",   {{(32-ADDR_W){1'b0}}, imem_addr}, 32'd0);
    check("rst_wdata",  imem_wdata, 32'd0);
    check("rst_done",   {31'd0, load_done}, 32'd0);
    check("rst_error",  {31'd0, load_error}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_ready",  {31'd0, rx_ready}, 32'd0);
    rst = 1'b1;
    neg();
    check("idle_ready", {31'd0, rx_ready}, 32'd1);

    // 1: 4-word program.
    load_prog1();
    run_frame(4, 1'b0, 0);

    // 2: bad checksum.
    run_frame(4, 1'b1, 0);

    // 3: zero length.
    run_frame(0, 1'b0, 0);

    // 4: oversize length, then ignored traffic.
    base = wr_cnt;
    put(8'hA5, 0);
    put(8'h01, 0);
    put(8'h01, 0);
    neg();
    rx_valid = 1'b0;
    check("ovs_busy",   {31'd0, busy}, 32'd0);
    check("ovs_error",  {31'd0, load_error}, 32'd1);
    check("ovs_cpurst", {31'd0, cpu_rst}, 32'd1);
    check("ovs_done",   {31'd0, load_done}, 32'd0);
    put(8'h00, 0);
    put(8'h11, 0);
    put(8'h04, 0);
    put(8'h5A, 0);
    neg();
    rx_valid = 1'b0;
    check("ovs_ign_busy",  {31'd0, busy}, 32'd0);
    check("ovs_ign_error", {31'd0, load_error}, 32'd1);
    check("ovs_writes",    32'(wr_cnt - base), 32'd0);

    // 5: noise then toggling valid.
    base = wr_cnt;
    put(8'h00, 1);
    put(8'hFF, 1);
    put(8'h3C, 1);
    neg();
    rx_valid = 1'b0;
    check("noise_busy",   {31'd0, busy}, 32'd0);
    check("noise_writes", 32'(wr_cnt - base), 32'd0);
    run_frame(4, 1'b0, 1);

    // 6: reset after two words, reload, then restart from DONE.
    put(8'hA5, 0);
    put(8'h04, 0);
    put(8'h00, 0);
    for (int k = 0; k < 2; k++) begin
      w = wq[k];
      for (int b = 0; b < 4; b++) put(w[8*b +: 8], 0);
      pend     = 1'b1;
      exp_addr = 32'(k);
      exp_data = w;
    end
    neg();
    rx_valid = 1'b0;
    rst = 1'b0;
    neg();
    check("mid_rst_cpurst", {31'd0, cpu_rst}, 32'd1);
    check("mid_rst_we",     {31'd0, imem_we}, 32'd0);
    check("mid_rst_addr",   {{(32-ADDR_W){1'b0}}, imem_addr}, 32'd0);
    check("mid_rst_wdata",  imem_wdata, 32'd0);
    check("mid_rst_done",   {31'd0, load_done}, 32'd0);
    check("mid_rst_error",  {31'd0, load_error}, 32'd0);
    check("mid_rst_busy",   {31'd0, busy}, 32'd0);
    check("mid_rst_ready",  {31'd0, rx_ready}, 32'd0);
    rst = 1'b1;
    run_frame(4, 1'b0, 0);
    put(8'hA5, 0);
    neg();
    rx_valid = 1'b0;
    check("restart_cpurst", {31'd0, cpu_rst}, 32'd1);
    check("restart_done",   {31'd0, load_done}, 32'd0);
    check("restart_busy",   {31'd0, busy}, 32'd1);
    rst = 1'b0;
    neg();
    rst = 1'b1;

    // Random programs with random stalls and random checksum corruption.
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 9);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back($urandom);
      run_frame(n, 1'($urandom_range(0, 1)), 2);
    end

    // Full-capacity image: last word lands at the top address without wrap.
    wq.delete();
    for (int k = 0; k < 2 ** ADDR_W; k++) wq.push_back($urandom);
    run_frame(2 ** ADDR_W, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
